// File: rtl/hamming_pkg.sv
// Shared Hamming(11,7) constants, decoded-word type and syndrome/extraction helpers.
// Used by hamming_decoder_pipe and its statistics counters.
package hamming_pkg;

    localparam int DATA_W = 7;
    localparam int CODE_W = 11;
    localparam int SYN_W  = 4;

    // Bit i of a mask corresponds to Hamming position i+1; a set bit means that position
    // contributes to the syndrome bit.
    localparam logic [CODE_W-1:0] MASK_S1 = 11'h555;
    localparam logic [CODE_W-1:0] MASK_S2 = 11'h666;
    localparam logic [CODE_W-1:0] MASK_S4 = 11'h078;
    localparam logic [CODE_W-1:0] MASK_S8 = 11'h780;

    localparam logic [SYN_W-1:0] SYN_LAST_POS = 4'd11;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SYN_W-1:0]  syndrome;
        logic              corrected;
        logic              uncorr;
    } dec_word_t;

    function automatic logic [SYN_W-1:0] hamming_syndrome(input logic [CODE_W-1:0] code);
        return {^(code & MASK_S8), ^(code & MASK_S4), ^(code & MASK_S2), ^(code & MASK_S1)};
    endfunction

    function automatic logic [DATA_W-1:0] hamming_extract(input logic [CODE_W-1:0] code);
        return {code[10:8], code[6:4], code[2]};
    endfunction

    // One-hot mask selecting code bit syn-1; only meaningful for syn in 1..11.
    function automatic logic [CODE_W-1:0] hamming_flip_mask(input logic [SYN_W-1:0] syn);
        logic [CODE_W-1:0] one;
        one = {{(CODE_W-1){1'b0}}, 1'b1};
        return one << (syn - 4'd1);
    endfunction

endpackage

// File: rtl/hamming_stat_counter.sv
// Saturating event counter with synchronous clear; clear takes priority over increment.
module hamming_stat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_r;
    logic             at_max_s;

    assign at_max_s = (cnt_r == {CNT_W{1'b1}});
    assign cnt      = cnt_r;

    // Count register: clear wins, then saturating increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc && !at_max_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/hamming_decoder_pipe.sv
// Two-stage backpressured Hamming(11,7) single-error-correcting decoder.
// Define HAMMING_DEC_STATS_EN to build the saturating corrected/uncorrectable counters.
module hamming_decoder_pipe
    import hamming_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter bit CORRECT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SYN_W-1:0]  out_syndrome,
    output logic              out_corrected,
    output logic              out_uncorr,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  stat_corr_cnt,
    output logic [CNT_W-1:0]  stat_unc_cnt
);

    logic              s1_valid_r;
    logic [CODE_W-1:0] s1_code_r;
    logic [SYN_W-1:0]  s1_syn_r;
    logic              s2_valid_r;
    dec_word_t         s2_word_r;

    logic              s1_ld_s;
    logic              s2_ld_s;
    logic              out_xfer_s;
    logic [CODE_W-1:0] fixed_code_s;
    dec_word_t         dec_s;

    // A stage loads when empty or when its current content leaves this cycle.
    assign s2_ld_s    = !s2_valid_r || out_ready;
    assign s1_ld_s    = !s1_valid_r || s2_ld_s;
    assign in_ready   = s1_ld_s;
    assign out_xfer_s = s2_valid_r && out_ready;

    // Stage 1: capture the codeword and its syndrome.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_code_r  <= {CODE_W{1'b0}};
            s1_syn_r   <= {SYN_W{1'b0}};
        end else if (s1_ld_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_code_r <= in_code;
                s1_syn_r  <= hamming_syndrome(in_code);
            end
        end
    end

    // Correction and data extraction from the stage-1 contents.
    always_comb begin
        fixed_code_s        = s1_code_r;
        dec_s.syndrome      = s1_syn_r;
        dec_s.corrected     = 1'b0;
        dec_s.uncorr        = 1'b0;
        if (s1_syn_r > SYN_LAST_POS) begin
            dec_s.uncorr = 1'b1;
        end else if ((s1_syn_r != 4'd0) && (CORRECT_EN == 1'b1)) begin
            fixed_code_s    = s1_code_r ^ hamming_flip_mask(s1_syn_r);
            dec_s.corrected = 1'b1;
        end else begin
            fixed_code_s = s1_code_r;
        end
        dec_s.data = hamming_extract(fixed_code_s);
    end

    // Stage 2: decoded-word output register, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_word_r  <= '{data: 7'd0, syndrome: 4'd0, corrected: 1'b0, uncorr: 1'b0};
        end else if (s2_ld_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_word_r <= dec_s;
            end
        end
    end

    assign out_valid     = s2_valid_r;
    assign out_data      = s2_word_r.data;
    assign out_syndrome  = s2_word_r.syndrome;
    assign out_corrected = s2_word_r.corrected;
    assign out_uncorr    = s2_word_r.uncorr;

`ifdef HAMMING_DEC_STATS_EN
    hamming_stat_counter #(
        .CNT_W (CNT_W)
    ) u_corr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stat_clr),
        .inc   (out_xfer_s && s2_word_r.corrected),
        .cnt   (stat_corr_cnt)
    );

    hamming_stat_counter #(
        .CNT_W (CNT_W)
    ) u_unc_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stat_clr),
        .inc   (out_xfer_s && s2_word_r.uncorr),
        .cnt   (stat_unc_cnt)
    );
`else
    logic unused_stat_s;

    assign stat_corr_cnt = {CNT_W{1'b0}};
    assign stat_unc_cnt  = {CNT_W{1'b0}};
    assign unused_stat_s = stat_clr ^ out_xfer_s;
`endif

endmodule
